// File: rtl/hwag_cfg_seq.sv
// rtl/hwag_cfg_seq.sv - register-file boot loader/verifier with host access port
`timescale 1ns/1ps
module hwag_cfg_seq #(
    parameter int NREG = 131,
    parameter int AW   = 8,
    parameter int DW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [AW-1:0] reg_addr,
    output logic [DW-1:0] reg_wdata,
    output logic          reg_we,
    output logic          reg_re,
    input  logic [DW-1:0] reg_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] err_addr
);

    typedef enum logic [2:0] {IDLE, FETCH, WRITE, RDREQ, CMP, DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(NREG - 1);

    state_t        state;
    logic [AW-1:0] idx;
    logic          host_rd;
    logic          host_gnt;

    // Host is served in the request cycle; rst gating keeps the bus quiet while in reset.
    assign host_gnt = rst && host_req && !start && (state == IDLE || state == DONE);
    assign rom_addr = idx;

    // Bus is decoded from registered state: ROM data only arrives during WRITE/CMP,
    // and a host read must return data together with its ack one cycle later.
    always_comb begin
        reg_addr  = '0;
        reg_wdata = '0;
        reg_we    = 1'b0;
        reg_re    = 1'b0;
        case (state)
            WRITE: begin
                reg_addr  = idx;
                reg_wdata = rom_data;
                reg_we    = 1'b1;
            end
            RDREQ: begin
                reg_addr = idx;
                reg_re   = 1'b1;
            end
            default: begin
                if (host_gnt) begin
                    reg_addr  = host_addr;
                    reg_wdata = host_wdata;
                    reg_we    = host_we;
                    reg_re    = !host_we;
                end
            end
        endcase
    end

    assign host_rdata = (host_ack && host_rd) ? reg_rdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_addr <= '0;
            host_ack <= 1'b0;
            host_rd  <= 1'b0;
        end else begin
            host_ack <= host_gnt;
            host_rd  <= host_gnt && !host_we;
            case (state)
                IDLE, DONE: begin
                    // IDLE is only left through the automatic reload after reset.
                    if (start || state == IDLE) begin
                        state    <= FETCH;
                        idx      <= '0;
                        err      <= 1'b0;
                        err_addr <= '0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                FETCH: state <= WRITE;
                WRITE: begin
                    if (idx < LAST) begin
                        idx   <= idx + 1'b1;
                        state <= FETCH;
                    end else begin
                        idx   <= '0;
                        state <= RDREQ;
                    end
                end
                RDREQ: state <= CMP;
                CMP: begin
                    if (reg_rdata != rom_data && !err) begin
                        err      <= 1'b1;
                        err_addr <= idx;
                    end
                    if (idx == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= RDREQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hwag_cfg_seq.sv
// tb/tb_hwag_cfg_seq.sv - randomized self-checking bench for hwag_cfg_seq
`timescale 1ns/1ps
module tb_hwag_cfg_seq;

    localparam int NREG     = 131;
    localparam int AW       = 8;
    localparam int DW       = 16;
    localparam int LOAD_CYC = 4 * NREG;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = '0;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic          reg_we, reg_re;
    logic [DW-1:0] reg_rdata = '0;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          busy, done, err;
    logic [AW-1:0] err_addr;

    hwag_cfg_seq #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .busy(busy), .done(done), .err(err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] rom    [256];
    logic [DW-1:0] mem    [256];
    logic [DW-1:0] shadow [256];
    bit            corrupt[256];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    // ROM and register-file models; corrupted entries read back one higher than stored
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rom_data <= rom[rom_addr];
        if (reg_we) mem[reg_addr] <= reg_wdata;
        if (reg_re) reg_rdata <= mem[reg_addr] + (corrupt[reg_addr] ? DW'(1) : DW'(0));
    end

    int t_busy = 0;
    bit busy_q = 1'b0;
    int n_wr = 0, n_rd = 0, bad_wr = 0, bad_rd = 0;
    int n_excl = 0, n_idx = 0, n_rstacc = 0;

    // Expected load traffic: writes 0..NREG-1 with ROM data, then reads 0..NREG-1
    always @(negedge clk) begin
        busy_q <= busy;
        if (busy && !busy_q) begin
            t_busy <= cyc;
            n_wr   <= 0;
            n_rd   <= 0;
            bad_wr <= 0;
            bad_rd <= 0;
        end else begin
            if (busy && reg_we) begin
                if (n_wr >= NREG || int'(reg_addr) != n_wr || reg_wdata !== rom[n_wr[7:0]])
                    bad_wr <= bad_wr + 1;
                n_wr <= n_wr + 1;
            end
            if (busy && reg_re) begin
                if (n_wr != NREG || int'(reg_addr) != n_rd) bad_rd <= bad_rd + 1;
                n_rd <= n_rd + 1;
            end
        end
        if (reg_we && reg_re) n_excl <= n_excl + 1;
        if (int'(rom_addr) > NREG - 1) n_idx <= n_idx + 1;
        if (!rst && (reg_we || reg_re)) n_rstacc <= n_rstacc + 1;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } op_t;
    op_t ops[$];

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        return shadow[a] + (corrupt[a] ? DW'(1) : DW'(0));
    endfunction

    task automatic wait_done();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < LOAD_CYC + 50);
        check("done_timeout", done, 1);
    endtask

    task automatic check_load(input bit exp_err, input int exp_err_addr);
        check("latency", cyc - t_busy, LOAD_CYC);
        check("n_writes", n_wr, NREG);
        check("bad_writes", bad_wr, 0);
        check("n_reads", n_rd, NREG);
        check("bad_reads", bad_rd, 0);
        check("err", err, exp_err);
        check("err_addr", err_addr, exp_err_addr);
        check("busy_in_done", busy, 0);
        for (int i = 0; i < NREG; i++) shadow[i] = rom[i];
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("start_clears_err", {busy, done, err}, 3'b100);
    endtask

    task automatic wait_offset(input int off);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (cyc - t_busy != off && k < LOAD_CYC);
        check("offset_reached", cyc - t_busy, off);
    endtask

    task automatic host_seq();
        bit            pend = 1'b0;
        logic [DW-1:0] pexp = '0;
        for (int i = 0; i <= ops.size(); i++) begin
            @(posedge clk); #1;
            if (i < ops.size()) begin
                host_req   = 1'b1;
                host_we    = ops[i].we;
                host_addr  = ops[i].addr;
                host_wdata = ops[i].wdata;
            end else begin
                host_req = 1'b0;
            end
            @(negedge clk);
            if (pend) begin
                check("host_ack", host_ack, 1);
                check("host_rdata", host_rdata, pexp);
            end
            pend = 1'b0;
            if (i < ops.size()) begin
                check("host_grant", {reg_we, reg_re, reg_addr}, {ops[i].we, ~ops[i].we, ops[i].addr});
                if (ops[i].we) begin
                    shadow[ops[i].addr] = ops[i].wdata;
                    pexp = '0;
                end else begin
                    pexp = model_read(ops[i].addr);
                end
                pend = 1'b1;
            end
        end
        ops.delete();
    endtask

    function automatic logic [DW+DW+AW+AW+AW+7-1:0] all_outs();
        return {rom_addr, reg_addr, reg_wdata, reg_we, reg_re, host_ack, host_rdata,
                busy, done, err, err_addr};
    endfunction

    initial begin
        int ncor, min_a, a;
        for (int i = 0; i < 256; i++) rom[i] = '0;
        rom[0] = 16'd128; rom[4] = 16'd57; rom[63] = 16'd7; rom[129] = 16'd3830;

        // Boot under reset with a stray host request; nothing may reach the bus
        host_req = 1'b1; host_addr = 8'd9;
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", all_outs(), 0);
        host_req = 1'b0;
        rst = 1'b1;

        // Auto-load with a host read of address 4 stalled from cycle 10
        repeat (10) @(posedge clk);
        #1 host_req = 1'b1; host_we = 1'b0; host_addr = 8'd4;
        wait_done();
        check("stall_grant", {reg_we, reg_re, reg_addr}, {2'b01, 8'd4});
        check_load(1'b0, 0);
        @(posedge clk); #1 host_req = 1'b0;
        @(negedge clk);
        check("stall_ack", host_ack, 1);
        check("stall_rdata", host_rdata, 57);

        ops.push_back('{1'b1, 8'd6, 16'h1234});
        ops.push_back('{1'b0, 8'd6, 16'h0000});
        host_seq();

        // Verify mismatches at 70 and 127; only the first is reported
        rom[70] = 16'd2;
        corrupt[70] = 1'b1; corrupt[127] = 1'b1;
        pulse_start();
        wait_done();
        check_load(1'b1, 70);

        // start and host together in DONE, then start during a mid-load FETCH
        @(posedge clk); #1 start = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 8'd63;
        @(negedge clk);
        check("start_priority", {reg_we, reg_re}, 2'b00);
        @(posedge clk); #1 start = 1'b0;
        wait_offset(41);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done();
        check("contend_grant", {reg_we, reg_re, reg_addr}, {2'b01, 8'd63});
        check_load(1'b1, 70);
        @(posedge clk); #1 host_req = 1'b0;
        @(negedge clk);
        check("contend_ack", host_ack, 1);
        check("contend_rdata", host_rdata, 7);

        // Reset in the verify phase, then a clean reload from idx 0
        corrupt[70] = 1'b0; corrupt[127] = 1'b0;
        pulse_start();
        wait_offset(299);
        @(posedge clk); #1 rst = 1'b0;
        #1 check("midrun_reset_outputs", all_outs(), 0);
        repeat (5) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        wait_done();
        check_load(1'b0, 0);
        check("reset_quiet", n_rstacc, 0);

        // Randomized ROM images, corruption sets and host traffic
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < NREG; i++) rom[i] = DW'($urandom);
            for (int i = 0; i < 256; i++) corrupt[i] = 1'b0;
            ncor  = int'($urandom_range(0, 2));
            min_a = NREG;
            for (int j = 0; j < ncor; j++) begin
                a = int'($urandom_range(0, NREG - 1));
                corrupt[a] = 1'b1;
                if (a < min_a) min_a = a;
            end
            pulse_start();
            wait_done();
            check_load(ncor > 0, (ncor > 0) ? min_a : 0);
            for (int j = 0; j < 8; j++)
                ops.push_back('{1'($urandom), AW'($urandom_range(0, NREG - 1)), DW'($urandom)});
            host_seq();
        end

        // Host read granted just before reset must never be acknowledged
        for (int i = 0; i < 256; i++) corrupt[i] = 1'b0;
        @(posedge clk); #1 host_req = 1'b1; host_we = 1'b0; host_addr = 8'd5;
        @(negedge clk);
        check("inflight_grant", reg_re, 1);
        #1 rst = 1'b0;
        @(posedge clk); #1 host_req = 1'b0;
        @(negedge clk);
        check("inflight_no_ack", host_ack, 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("inflight_no_ack_after", host_ack, 0);
        end
        wait_done();
        check_load(1'b0, 0);

        check("we_re_exclusive", n_excl, 0);
        check("idx_bound", n_idx, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
